// File: rtl/mem_turn_score_if.sv
// Pick handshake between the board controller (master) and the turn sequencer (slave).
interface mem_turn_score_if #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned VAL_W = 4
);
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [VAL_W-1:0] pick_val;
    logic             pick_empty;
    logic             pick_err;

    modport master (
        output pick_valid,
        output pick_idx,
        output pick_val,
        output pick_empty,
        input  pick_err
    );

    modport slave (
        input  pick_valid,
        input  pick_idx,
        input  pick_val,
        input  pick_empty,
        output pick_err
    );
endinterface

// File: rtl/mem_turn_score.sv
// Turn sequencer and scoreboard for the memory card game (N players, configurable deck).
// Define MEM_TURN_TIMEOUT_EN to enable the per-turn pick timeout.
module mem_turn_score #(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned NUM_PAIRS      = 8,
    parameter int unsigned VAL_W          = 4,
    parameter int unsigned IDX_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned PL_W    = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int unsigned SCORE_W = $clog2(NUM_PAIRS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           new_game,
    mem_turn_score_if.slave                pick,
    output logic [PL_W-1:0]                cur_player,
    output logic [IDX_W-1:0]               sel1_idx,
    output logic [IDX_W-1:0]               sel2_idx,
    output logic                           sel1_vld,
    output logic                           match,
    output logic                           mismatch,
    output logic                           timeout,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [SCORE_W-1:0]             pairs_found,
    output logic [1:0]                     status,
    output logic [PL_W-1:0]                winner
);

    typedef enum logic [1:0] {StFirst, StSecond, StResolve, StDone} state_e;

    localparam logic [1:0] StatPlay    = 2'b00;
    localparam logic [1:0] StatResolve = 2'b01;
    localparam logic [1:0] StatWin     = 2'b10;
    localparam logic [1:0] StatTie     = 2'b11;

    localparam logic [SCORE_W-1:0] MaxScore = SCORE_W'(NUM_PAIRS);

    state_e                               state_q, state_d;
    logic [PL_W-1:0]                      player_q, player_d;
    logic [IDX_W-1:0]                     sel1_idx_q, sel1_idx_d;
    logic [IDX_W-1:0]                     sel2_idx_q, sel2_idx_d;
    logic [VAL_W-1:0]                     sel1_val_q, sel1_val_d;
    logic                                 sel1_vld_q, sel1_vld_d;
    logic                                 match_q, match_d;
    logic                                 mismatch_q, mismatch_d;
    logic                                 err_q, err_d;
    logic                                 timeout_q, timeout_d;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]  scores_q, scores_d;
    logic [SCORE_W-1:0]                   pairs_q, pairs_d;
    logic [1:0]                           status_q, status_d;
    logic [PL_W-1:0]                      winner_q, winner_d;

    logic [PL_W-1:0]    next_player;
    logic [SCORE_W-1:0] top_score;
    logic [PL_W-1:0]    top_idx;
    logic               multi_top;
    logic               tmo_hit;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == MaxScore) ? v : v + SCORE_W'(1);
    endfunction

    // Explicit wrap so non-power-of-2 player counts rotate correctly.
    assign next_player = (player_q == PL_W'(NUM_PLAYERS - 1)) ? '0 : player_q + PL_W'(1);

    always_comb begin
        top_score = '0;
        top_idx   = '0;
        multi_top = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (scores_q[p] > top_score) begin
                top_score = scores_q[p];
                top_idx   = PL_W'(p);
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (scores_q[p] == top_score && PL_W'(p) != top_idx) begin
                multi_top = 1'b1;
            end
        end
    end

`ifdef MEM_TURN_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tmo_hit = (state_q == StFirst || state_q == StSecond) &&
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Restart on any accepted pick (state advances) and whenever outside the pick states.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (new_game || tmo_hit || state_d != state_q ||
            !(state_q == StFirst || state_q == StSecond)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo_hit            = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        sel1_idx_d = sel1_idx_q;
        sel2_idx_d = sel2_idx_q;
        sel1_val_d = sel1_val_q;
        sel1_vld_d = sel1_vld_q;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        err_d      = 1'b0;
        timeout_d  = 1'b0;
        scores_d   = scores_q;
        pairs_d    = pairs_q;
        status_d   = status_q;
        winner_d   = winner_q;

        unique case (state_q)
            StFirst: begin
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    player_d  = next_player;
                end else if (pick.pick_valid) begin
                    if (pick.pick_empty) begin
                        sel1_idx_d = pick.pick_idx;
                        sel1_val_d = pick.pick_val;
                        sel1_vld_d = 1'b1;
                        state_d    = StSecond;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSecond: begin
                if (tmo_hit) begin
                    timeout_d  = 1'b1;
                    player_d   = next_player;
                    sel1_vld_d = 1'b0;
                    state_d    = StFirst;
                end else if (pick.pick_valid) begin
                    if (pick.pick_empty && pick.pick_idx != sel1_idx_q) begin
                        sel2_idx_d = pick.pick_idx;
                        sel1_vld_d = 1'b0;
                        status_d   = StatResolve;
                        state_d    = StResolve;
                        if (pick.pick_val == sel1_val_q) begin
                            match_d            = 1'b1;
                            scores_d[player_q] = sat_inc(scores_q[player_q]);
                            pairs_d            = sat_inc(pairs_q);
                        end else begin
                            mismatch_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StResolve: begin
                // mismatch_q is still high here, so it tells how the turn ended.
                if (pairs_q == MaxScore) begin
                    state_d  = StDone;
                    status_d = multi_top ? StatTie : StatWin;
                    winner_d = multi_top ? '0 : top_idx;
                end else begin
                    state_d  = StFirst;
                    status_d = StatPlay;
                    if (mismatch_q) begin
                        player_d = next_player;
                    end
                end
            end
            StDone: begin
            end
        endcase

        if (new_game) begin
            state_d    = StFirst;
            player_d   = '0;
            sel1_idx_d = '0;
            sel2_idx_d = '0;
            sel1_val_d = '0;
            sel1_vld_d = 1'b0;
            match_d    = 1'b0;
            mismatch_d = 1'b0;
            err_d      = 1'b0;
            timeout_d  = 1'b0;
            scores_d   = '0;
            pairs_d    = '0;
            status_d   = StatPlay;
            winner_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFirst;
            player_q   <= '0;
            sel1_idx_q <= '0;
            sel2_idx_q <= '0;
            sel1_val_q <= '0;
            sel1_vld_q <= 1'b0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            scores_q   <= '0;
            pairs_q    <= '0;
            status_q   <= StatPlay;
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            player_q   <= player_d;
            sel1_idx_q <= sel1_idx_d;
            sel2_idx_q <= sel2_idx_d;
            sel1_val_q <= sel1_val_d;
            sel1_vld_q <= sel1_vld_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            scores_q   <= scores_d;
            pairs_q    <= pairs_d;
            status_q   <= status_d;
            winner_q   <= winner_d;
        end
    end

    assign cur_player    = player_q;
    assign sel1_idx      = sel1_idx_q;
    assign sel2_idx      = sel2_idx_q;
    assign sel1_vld      = sel1_vld_q;
    assign match         = match_q;
    assign mismatch      = mismatch_q;
    assign pick.pick_err = err_q;
    assign timeout       = timeout_q;
    assign scores        = scores_q;
    assign pairs_found   = pairs_q;
    assign status        = status_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_mem_turn_score.sv
// Self-checking bench for mem_turn_score: directed game scenarios plus randomized picks
// compared every cycle against a turn-level reference model.
module tb_mem_turn_score;

    localparam int NP      = 3;
    localparam int NPAIRS  = 8;
    localparam int VAL_W   = 4;
    localparam int IDX_W   = 8;
    localparam int TMO     = 16;
    localparam int PL_W    = ($clog2(NP) > 1) ? $clog2(NP) : 1;
    localparam int SCORE_W = $clog2(NPAIRS + 1);

    logic clk = 1'b0;
    logic rst;
    logic new_game;
    always #5 clk = ~clk;

    mem_turn_score_if #(.IDX_W(IDX_W), .VAL_W(VAL_W)) pif ();

    logic [PL_W-1:0]       cur_player;
    logic [IDX_W-1:0]      sel1_idx;
    logic [IDX_W-1:0]      sel2_idx;
    logic                  sel1_vld;
    logic                  match;
    logic                  mismatch;
    logic                  timeout;
    logic [NP*SCORE_W-1:0] scores;
    logic [SCORE_W-1:0]    pairs_found;
    logic [1:0]            status;
    logic [PL_W-1:0]       winner;

    mem_turn_score #(
        .NUM_PLAYERS   (NP),
        .NUM_PAIRS     (NPAIRS),
        .VAL_W         (VAL_W),
        .IDX_W         (IDX_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .pick       (pif),
        .cur_player (cur_player),
        .sel1_idx   (sel1_idx),
        .sel2_idx   (sel2_idx),
        .sel1_vld   (sel1_vld),
        .match      (match),
        .mismatch   (mismatch),
        .timeout    (timeout),
        .scores     (scores),
        .pairs_found(pairs_found),
        .status     (status),
        .winner     (winner)
    );

    int checks;
    int failures;
    bit chk_en;

    // Reference model: phase 0 wait first pick, 1 wait second, 2 resolving, 3 game over.
    int m_phase, m_player, m_sel1, m_sel2, m_val1, m_pairs, m_status, m_winner, m_cnt;
    int m_scores[NP];
    bit m_vld, m_last_mis, e_match, e_mismatch, e_err, e_tmo;

    function automatic void model_reset();
        m_phase = 0; m_player = 0; m_sel1 = 0; m_sel2 = 0; m_val1 = 0;
        m_pairs = 0; m_status = 0; m_winner = 0; m_cnt = 0;
        m_vld = 0; m_last_mis = 0;
        e_match = 0; e_mismatch = 0; e_err = 0; e_tmo = 0;
        for (int p = 0; p < NP; p++) m_scores[p] = 0;
    endfunction

    function automatic void model_game_over();
        int best;
        int holders;
        int who;
        best = -1; holders = 0; who = 0;
        for (int p = 0; p < NP; p++) if (m_scores[p] > best) best = m_scores[p];
        for (int p = 0; p < NP; p++) begin
            if (m_scores[p] == best) begin
                holders++;
                who = p;
            end
        end
        m_status = (holders == 1) ? 2 : 3;
        m_winner = (holders == 1) ? who : 0;
    endfunction

    function automatic void model_step(bit ng, bit v, int idx, int val, bit emp);
        bit ok;
        e_match = 0; e_mismatch = 0; e_err = 0; e_tmo = 0;
        if (ng) begin
            model_reset();
            return;
        end
        if (m_phase <= 1) begin
`ifdef MEM_TURN_TIMEOUT_EN
            if (m_cnt == TMO - 1) begin
                e_tmo = 1; m_vld = 0; m_phase = 0; m_cnt = 0;
                m_player = (m_player + 1) % NP;
                return;
            end
            m_cnt++;
`endif
            if (v) begin
                ok = emp && !(m_phase == 1 && idx == m_sel1);
                if (!ok) begin
                    e_err = 1;
                end else if (m_phase == 0) begin
                    m_sel1 = idx; m_val1 = val; m_vld = 1; m_phase = 1; m_cnt = 0;
                end else begin
                    m_sel2 = idx; m_vld = 0; m_phase = 2; m_status = 1; m_cnt = 0;
                    m_last_mis = (val != m_val1);
                    if (m_last_mis) begin
                        e_mismatch = 1;
                    end else begin
                        e_match = 1;
                        if (m_scores[m_player] < NPAIRS) m_scores[m_player]++;
                        if (m_pairs < NPAIRS) m_pairs++;
                    end
                end
            end
        end else if (m_phase == 2) begin
            m_cnt = 0;
            if (m_pairs == NPAIRS) begin
                m_phase = 3;
                model_game_over();
            end else begin
                m_phase = 0; m_status = 0;
                if (m_last_mis) m_player = (m_player + 1) % NP;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step(new_game, pif.pick_valid, int'(pif.pick_idx), int'(pif.pick_val),
                        pif.pick_empty);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int score_of(input int p);
        return int'(scores[p*SCORE_W +: SCORE_W]);
    endfunction

    task automatic compare_all();
        check("cur_player", 32'(cur_player), m_player);
        check("sel1_idx", 32'(sel1_idx), m_sel1);
        check("sel2_idx", 32'(sel2_idx), m_sel2);
        check("sel1_vld", 32'(sel1_vld), 32'(m_vld));
        check("match", 32'(match), 32'(e_match));
        check("mismatch", 32'(mismatch), 32'(e_mismatch));
        check("pick_err", 32'(pif.pick_err), 32'(e_err));
        check("timeout", 32'(timeout), 32'(e_tmo));
        check("pairs_found", 32'(pairs_found), m_pairs);
        check("status", 32'(status), m_status);
        check("winner", 32'(winner), m_winner);
        for (int p = 0; p < NP; p++) check($sformatf("score%0d", p), score_of(p), m_scores[p]);
    endtask

    always @(negedge clk) if (chk_en) compare_all();

    task automatic drive(input logic ng, input logic v, input int idx, input int val,
                         input logic emp);
        new_game       = ng;
        pif.pick_valid = v;
        pif.pick_idx   = IDX_W'(idx);
        pif.pick_val   = VAL_W'(val);
        pif.pick_empty = emp;
        @(posedge clk);
        @(negedge clk);
        new_game       = 1'b0;
        pif.pick_valid = 1'b0;
    endtask

    task automatic pick(input int idx, input int val);
        drive(1'b0, 1'b1, idx, val, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic turn(input int i1, input int v1, input int i2, input int v2);
        pick(i1, v1);
        pick(i2, v2);
        idle(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fired;
        checks = 0; failures = 0; chk_en = 0;
        rst = 1'b1; new_game = 1'b0;
        pif.pick_valid = 1'b0; pif.pick_idx = '0; pif.pick_val = '0; pif.pick_empty = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        check("rst_status", 32'(status), 0);
        check("rst_vld", 32'(sel1_vld), 0);
        check("rst_pairs", 32'(pairs_found), 0);

        // P0 matches value 5 at idx 3 / 9.
        pick(3, 5);
        pick(9, 5);
        check("t1_match", 32'(match), 1);
        check("t1_score0", score_of(0), 1);
        check("t1_pairs", 32'(pairs_found), 1);
        check("t1_status_resolve", 32'(status), 1);
        idle(1);
        check("t1_player", 32'(cur_player), 0);
        check("t1_status_play", 32'(status), 0);

        // Three mismatching turns: P0 -> P1 -> P2 -> wraps to P0.
        turn(1, 1, 2, 2);
        turn(4, 1, 5, 2);
        check("t2_player2", 32'(cur_player), 2);
        pick(10, 4);
        pick(11, 7);
        check("t2_mismatch", 32'(mismatch), 1);
        idle(1);
        check("t2_wrap", 32'(cur_player), 0);
        check("t2_score0", score_of(0), 1);

        // Rejections while waiting for the second pick.
        pick(3, 5);
        pick(3, 5);
        check("rej_repeat_err", 32'(pif.pick_err), 1);
        check("rej_repeat_vld", 32'(sel1_vld), 1);
        drive(1'b0, 1'b1, 6, 5, 1'b0);
        check("rej_empty_err", 32'(pif.pick_err), 1);
        check("rej_empty_vld", 32'(sel1_vld), 1);
        pick(12, 5);
        idle(1);
        check("rej_then_score", score_of(0), 2);

        // Finish 5/3/0: P0 three more pairs, one miss, P1 three pairs.
        for (int t = 0; t < 3; t++) turn(20 + t, 3, 40 + t, 3);
        turn(1, 0, 2, 1);
        for (int t = 0; t < 3; t++) turn(50 + t, 2, 60 + t, 2);
        check("win_status", 32'(status), 2);
        check("win_winner", 32'(winner), 0);
        check("win_score1", score_of(1), 3);
        pick(70, 1);
        check("done_no_err", 32'(pif.pick_err), 0);

        // new_game beats a simultaneous pick.
        drive(1'b1, 1'b1, 7, 7, 1'b1);
        check("ng_vld", 32'(sel1_vld), 0);
        check("ng_sel1", 32'(sel1_idx), 0);
        check("ng_status", 32'(status), 0);

        // Tie 4/4/0.
        for (int t = 0; t < 4; t++) turn(20 + t, 3, 40 + t, 3);
        turn(1, 0, 2, 1);
        for (int t = 0; t < 4; t++) turn(50 + t, 2, 60 + t, 2);
        check("tie_status", 32'(status), 3);
        check("tie_winner", 32'(winner), 0);

        // Async reset mid-turn with a score of 2.
        drive(1'b1, 1'b0, 0, 0, 1'b1);
        turn(1, 1, 2, 1);
        turn(3, 2, 4, 2);
        pick(20, 1);
        check("pre_rst_vld", 32'(sel1_vld), 1);
        #2 rst = 1'b1;
        #1;
        check("async_vld", 32'(sel1_vld), 0);
        check("async_score0", score_of(0), 0);
        check("async_pairs", 32'(pairs_found), 0);
        compare_all();
        @(negedge clk);
        rst = 1'b0;

`ifdef MEM_TURN_TIMEOUT_EN
        pick(30, 1);
        fired = 0;
        for (int i = 0; i < 40 && !fired; i++) begin
            idle(1);
            if (timeout) fired = 1;
        end
        check("tmo_fired", 32'(fired), 1);
        check("tmo_vld", 32'(sel1_vld), 0);
        check("tmo_player", 32'(cur_player), 1);
`else
        fired = 0;
`endif

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            bit ng;
            ng = ($urandom_range(0, 63) == 0);
            drive(ng, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 6) != 0));
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
